nios2_debug_jtag_host: RTL and testbench
========================================

NIOS2_DEBUG_JTAG_HOST -- requirements
Module: nios2_debug_jtag_host

Interface
REQ-001 Parameter TCK_DIV, default 2: clk cycles per vji_tck half-period, legal range 1..255.
REQ-002 Parameter RTI_CYCLES, default 1: vji_tck periods spent in run-test-idle after each update, legal range 1..15.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE with no pending response.
REQ-007 cmd_ir  in  2  virtual IR value for the command.
REQ-008 cmd_data  in  38  DR value to shift, LSB first.
REQ-009 rsp_valid  out  1  captured DR available; held until rsp_ready.
REQ-010 rsp_ready  in  1  response accept.
REQ-011 rsp_data  out  38  captured vji_tdo bits; bit 0 = first captured bit.
REQ-012 vji_tck, vji_tdi  out  1 each  generated test clock and data.
REQ-013 vji_tdo  in  1  serial data returned by the debug slave.
REQ-014 vji_ir_in  out  2  virtual IR presented to the slave.
REQ-015 vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  one-hot virtual JTAG state strobes.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, UIR, CDR, SDR, UDR, RTI, RSP; vji_uir/cdr/sdr/udr/rti high exactly while in the matching state.
REQ-018 vji_tck SHALL be 0 in IDLE and RSP; in other states, low for TCK_DIV clks then high for TCK_DIV clks per period, each state starting on a low phase.
REQ-019 State transitions other than IDLE->UIR and RSP->IDLE SHALL occur only on the clk where vji_tck falls (end of a period).
REQ-020 cmd_valid&cmd_ready SHALL latch cmd_ir into vji_ir_in and cmd_data into the shift register; IDLE->UIR.
REQ-021 UIR, CDR and UDR SHALL each last exactly one tck period; RTI SHALL last RTI_CYCLES periods.
REQ-022 SDR SHALL last exactly 38 periods, tracked by a 6-bit bit counter.
REQ-023 vji_tdi SHALL equal shift-register bit 0 throughout each SDR period; vji_tdi is 0 outside SDR.
REQ-024 vji_tdo SHALL be sampled on the clk where vji_tck rises in SDR; at the following fall, the register shifts right with the sample entering bit 37.
REQ-025 vji_ir_in SHALL hold its value from latch until the next accepted command.
REQ-026 The last RTI period end SHALL enter RSP; rsp_valid=1 and rsp_data=shift register from that clk.
REQ-027 rsp_valid&rsp_ready SHALL clear rsp_valid next clk and return to IDLE; rsp_data holds its last value.
REQ-028 Total latency from accept clk to first rsp_valid clk SHALL be 2*TCK_DIV*(41+RTI_CYCLES) clks (168 at defaults).
REQ-029 cmd_valid during busy SHALL be ignored; cmd_data/cmd_ir changes after accept SHALL have no effect.

Reset
REQ-030 Reset SHALL force IDLE, all vji_* outputs 0, rsp_valid 0, rsp_data 0, busy 0, bit counter and divider 0, shift register 0.
REQ-031 Reset mid-operation SHALL abort immediately with no rsp_valid; cmd_ready=1 on the first clk after reset deasserts.

Configuration
REQ-032 Macro DEBUG_HOST_IR_CACHE_EN defined: module keeps a cached-IR-valid flag; accepted command with cmd_ir equal to vji_ir_in and flag set SHALL go IDLE->CDR, skipping UIR (latency 2*TCK_DIV*(40+RTI_CYCLES)); flag set after each UIR, cleared by reset.
REQ-033 DEBUG_HOST_IR_CACHE_EN undefined: every command SHALL pass through UIR; no cache flag exists.

Verification
REQ-034 Defaults, vji_tdo looped to vji_tdi, cmd_ir=2'b01, cmd_data=38'h2_A5A5_5A5A -> rsp_data=38'h2_A5A5_5A5A, rsp_valid at clk 168, exactly 38 sdr tck rises.
REQ-035 vji_tdo tied 1, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF; vji_tdi 0 throughout SDR; vji_ir_in=cmd_ir through RTI.
REQ-036 rsp_ready held 0 for 50 clks after rsp_valid -> rsp_valid, rsp_data stable, cmd_ready 0, cmd_valid pulses ignored; rsp_ready=1 -> IDLE next clk.
REQ-037 reset asserted on 10th SDR tck period -> next clk all strobes 0, vji_tck 0, no rsp_valid; new command afterwards completes normally.
REQ-038 Macro defined, two commands both cmd_ir=2'b10 -> first has one UIR period, second has none and rsp at clk 164; third with cmd_ir=2'b00 has UIR again.
REQ-039 TCK_DIV=1, RTI_CYCLES=3 -> vji_tck toggles every clk, rsp_valid at clk 88, three rti tck periods.

Source files
------------

// File: rtl/nios2_debug_jtag_host.sv
`default_nettype none
//==============================================================================
// Module      : nios2_debug_jtag_host
// Description : Virtual-JTAG host that issues one IR/DR scan per command
//               (UIR, CDR, 38-bit SDR, UDR, RTI) to a Nios II debug slave and
//               returns the captured DR. Optional macro DEBUG_HOST_IR_CACHE_EN
//               skips the UIR scan when the requested IR is already loaded.
// Revision    : 1.0 - initial release
//==============================================================================
module nios2_debug_jtag_host #(
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ir,
    input  logic [37:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [37:0] rsp_data,
    output logic        vji_tck,
    output logic        vji_tdi,
    input  logic        vji_tdo,
    output logic [1:0]  vji_ir_in,
    output logic        vji_uir,
    output logic        vji_cdr,
    output logic        vji_sdr,
    output logic        vji_udr,
    output logic        vji_rti,
    output logic        busy
);

    localparam int         c_dr_len   = 38;
    localparam logic [7:0] c_div_last = 8'(TCK_DIV - 1);
    localparam logic [5:0] c_sdr_last = 6'(c_dr_len - 1);
    localparam logic [5:0] c_rti_last = 6'(RTI_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_div;
    logic        r_tck;
    logic [5:0]  r_bit_cnt;
    logic [37:0] r_shift;
    logic        r_tdo_smp;
    logic [1:0]  r_ir;
    logic        r_rsp_valid;
    logic [37:0] r_rsp_data;

    logic w_accept;
    logic w_tck_run;
    logic w_phase_end;
    logic w_tck_rise;
    logic w_tck_fall;
    logic w_ir_hit;

    assign cmd_ready   = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_tck_run   = (r_state != S_IDLE) && (r_state != S_RSP);
    assign w_phase_end = w_tck_run && (r_div == c_div_last);
    assign w_tck_rise  = w_phase_end && !r_tck;
    assign w_tck_fall  = w_phase_end && r_tck;

`ifdef DEBUG_HOST_IR_CACHE_EN
    // Cached IR is trusted only once a UIR scan has actually loaded it.
    logic r_ir_cached;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_cached <= 1'b0;
        end else if ((r_state == S_UIR) && w_tck_fall) begin
            r_ir_cached <= 1'b1;
        end
    end

    assign w_ir_hit = r_ir_cached && (cmd_ir == r_ir);
`else
    assign w_ir_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_tck       <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tdo_smp   <= 1'b0;
            r_ir        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            // Every scan state begins on a low tck phase with a fresh divider.
            if (!w_tck_run) begin
                r_div <= '0;
                r_tck <= 1'b0;
            end else if (w_phase_end) begin
                r_div <= '0;
                r_tck <= ~r_tck;
            end else begin
                r_div <= r_div + 8'd1;
            end

            if ((r_state == S_SDR) && w_tck_rise) begin
                r_tdo_smp <= vji_tdo;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ir      <= cmd_ir;
                        r_shift   <= cmd_data;
                        r_bit_cnt <= '0;
                        r_state   <= w_ir_hit ? S_CDR : S_UIR;
                    end
                end
                S_UIR: begin
                    if (w_tck_fall) begin
                        r_state <= S_CDR;
                    end
                end
                S_CDR: begin
                    if (w_tck_fall) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_SDR;
                    end
                end
                S_SDR: begin
                    if (w_tck_fall) begin
                        r_shift <= {r_tdo_smp, r_shift[37:1]};
                        if (r_bit_cnt == c_sdr_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_UDR;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                S_UDR: begin
                    if (w_tck_fall) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_RTI;
                    end
                end
                S_RTI: begin
                    if (w_tck_fall) begin
                        if (r_bit_cnt == c_rti_last) begin
                            r_bit_cnt   <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_shift;
                            r_state     <= S_RSP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vji_tck   = r_tck;
    assign vji_tdi   = (r_state == S_SDR) && r_shift[0];
    assign vji_ir_in = r_ir;
    assign vji_uir   = (r_state == S_UIR);
    assign vji_cdr   = (r_state == S_CDR);
    assign vji_sdr   = (r_state == S_SDR);
    assign vji_udr   = (r_state == S_UDR);
    assign vji_rti   = (r_state == S_RTI);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_jtag_host.sv
`default_nettype none
//==============================================================================
// Module      : tb_nios2_debug_jtag_host
// Description : Randomized self-checking bench for nios2_debug_jtag_host.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_nios2_debug_jtag_host;

    parameter int TB_TCK_DIV = 2;
    parameter int TB_RTI     = 1;

    localparam int c_budget = 2 * TB_TCK_DIV * (41 + TB_RTI) + 40;

`ifdef DEBUG_HOST_IR_CACHE_EN
    localparam bit c_cache = 1'b1;
`else
    localparam bit c_cache = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [37:0] rsp_data;
    logic        vji_tck;
    logic        vji_tdi;
    logic        vji_tdo = 1'b0;
    logic [1:0]  vji_ir_in;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic        busy;

    nios2_debug_jtag_host #(
        .TCK_DIV    (TB_TCK_DIV),
        .RTI_CYCLES (TB_RTI)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .vji_tck   (vji_tck),
        .vji_tdi   (vji_tdi),
        .vji_tdo   (vji_tdo),
        .vji_ir_in (vji_ir_in),
        .vji_uir   (vji_uir),
        .vji_cdr   (vji_cdr),
        .vji_sdr   (vji_sdr),
        .vji_udr   (vji_udr),
        .vji_rti   (vji_rti),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] rnd38();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    // Slave-side observer: counts tck rises per scan state, records tdi bits
    // shifted out, and drives tdo either as loopback or from a bit pattern.
    int          n_sdr, n_uir, n_cdr, n_udr, n_rti;
    int          n_bad_tdi, n_bad_tck, n_bad_ir, n_bad_hot;
    logic [37:0] tdi_seen;
    logic [37:0] tdo_pat  = '0;
    bit          tdo_loop = 1'b0;
    logic [1:0]  exp_ir   = '0;
    logic        prev_tck = 1'b0;

    always @(negedge clk) begin
        if (vji_tck && !prev_tck) begin
            if (vji_sdr) begin
                if (n_sdr < 38) tdi_seen[n_sdr] = vji_tdi;
                n_sdr++;
            end
            if (vji_uir) n_uir++;
            if (vji_cdr) n_cdr++;
            if (vji_udr) n_udr++;
            if (vji_rti) n_rti++;
        end
        prev_tck = vji_tck;
        if (vji_tdi && !vji_sdr) n_bad_tdi++;
        if (vji_tck && !busy) n_bad_tck++;
        if (busy && (vji_ir_in !== exp_ir)) n_bad_ir++;
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) n_bad_hot++;
        vji_tdo = tdo_loop ? vji_tdi : tdo_pat[(n_sdr < 38) ? n_sdr : 37];
    end

    task automatic clear_counts();
        n_sdr = 0; n_uir = 0; n_cdr = 0; n_udr = 0; n_rti = 0;
        n_bad_tdi = 0; n_bad_tck = 0; n_bad_ir = 0; n_bad_hot = 0;
    endtask

    bit         m_cache_vld = 1'b0;
    logic [1:0] m_last_ir   = '0;

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_cmd(input logic [1:0] ir, input logic [37:0] data, input bit loop,
                           input logic [37:0] pat, input int stall);
        int          n;
        int          exp_lat;
        int          stall_bad;
        bit          got;
        bit          skip;
        logic [37:0] exp_rsp;
        skip    = c_cache && m_cache_vld && (ir == m_last_ir);
        exp_lat = 2 * TB_TCK_DIV * (41 + TB_RTI) - (skip ? 2 * TB_TCK_DIV : 0);
        exp_rsp = loop ? data : pat;

        wait_ready();
        tdo_loop  = loop;
        tdo_pat   = pat;
        exp_ir    = ir;
        tdi_seen  = '0;
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        @(posedge clk);
        #1;
        clear_counts();

        // Busy-time noise on the command port must not disturb the scan.
        n   = 0;
        got = 1'b0;
        while (!got && n < c_budget) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_ir    = 2'($urandom_range(0, 3));
            cmd_data  = rnd38();
            @(posedge clk);
            n++;
            #1;
            got = rsp_valid;
        end
        chk("rsp_seen", 64'(got), 64'd1);
        chk("rsp_latency", 64'(n), 64'(exp_lat));
        chk("rsp_data", 64'(rsp_data), 64'(exp_rsp));
        chk("sdr_rises", 64'(n_sdr), 64'd38);
        chk("uir_periods", 64'(n_uir), skip ? 64'd0 : 64'd1);
        chk("cdr_periods", 64'(n_cdr), 64'd1);
        chk("udr_periods", 64'(n_udr), 64'd1);
        chk("rti_periods", 64'(n_rti), 64'(TB_RTI));
        chk("tdi_sequence", 64'(tdi_seen), 64'(data));
        chk("tdi_outside_sdr", 64'(n_bad_tdi), 64'd0);
        chk("tck_when_idle", 64'(n_bad_tck), 64'd0);
        chk("ir_in_hold", 64'(n_bad_ir), 64'd0);
        chk("strobe_onehot", 64'(n_bad_hot), 64'd0);

        stall_bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            if (!rsp_valid || (rsp_data !== exp_rsp) || cmd_ready || !busy) stall_bad++;
        end
        chk("stall_hold", 64'(stall_bad), 64'd0);

        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_clear", 64'(rsp_valid), 64'd0);
        chk("idle_after_rsp", 64'(cmd_ready), 64'd1);
        chk("rsp_data_hold", 64'(rsp_data), 64'(exp_rsp));
        @(negedge clk);
        rsp_ready = 1'b0;
        m_cache_vld = 1'b1;
        m_last_ir   = ir;
    endtask

    task automatic run_reset_mid();
        int n;
        wait_ready();
        tdo_loop  = 1'b1;
        exp_ir    = 2'b11;
        cmd_valid = 1'b1;
        cmd_ir    = 2'b11;
        cmd_data  = rnd38();
        @(posedge clk);
        #1;
        clear_counts();
        cmd_valid = 1'b0;
        n = 0;
        while (n_sdr < 10 && n < c_budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_sdr_period10", 64'({vji_sdr, 6'(n_sdr)}), 64'({1'b1, 6'd10}));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        chk("abort_tck_tdi", 64'({vji_tck, vji_tdi}), 64'd0);
        chk("abort_rsp", 64'({rsp_valid, busy}), 64'd0);
        chk("abort_rsp_data", 64'(rsp_data), 64'd0);
        chk("abort_ir_in", 64'(vji_ir_in), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_abort", 64'(cmd_ready), 64'd1);
        chk("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
        m_cache_vld = 1'b0;
        m_last_ir   = '0;
        exp_ir      = '0;
    endtask

    initial begin
        logic [1:0] ir;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp", 64'({rsp_valid, busy}), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_vji", 64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        run_cmd(2'b01, 38'h2_A5A5_5A5A, 1'b1, '0, 0);
        run_cmd(2'b01, 38'h0, 1'b0, 38'h3F_FFFF_FFFF, 3);
        run_cmd(2'b10, rnd38(), 1'b0, rnd38(), 50);
        run_cmd(2'b10, rnd38(), 1'b1, '0, 1);
        run_cmd(2'b00, rnd38(), 1'b0, rnd38(), 0);
        run_reset_mid();
        run_cmd(2'b00, rnd38(), 1'b1, '0, 2);

        for (int k = 0; k < 8; k++) begin
            ir = ($urandom_range(0, 1) == 0) ? m_last_ir : 2'($urandom_range(0, 3));
            run_cmd(ir, rnd38(), 1'($urandom_range(0, 1)), rnd38(), int'($urandom_range(0, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
